// File: rtl/fanout_pkg.sv
// Shared types and defaults for the eager-fork broadcast stage.
// Optional statistics counters are enabled by defining FANOUT_FORK_STATS_EN.
package fanout_pkg;

    localparam int unsigned NUM_OUT_DEFAULT = 7;
    localparam int unsigned DATA_W_DEFAULT  = 17;
    localparam int unsigned CNT_W_DEFAULT   = 32;

    typedef logic [NUM_OUT_DEFAULT-1:0] out_mask_t;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } fork_state_t;

    function automatic out_mask_t act_mask_f(input out_mask_t en, input out_mask_t sel);
        return en & sel;
    endfunction

endpackage

// File: rtl/fanout_done_tracker.sv
// Per-destination acceptance tracking: remembers which consumers already took the held token
// and decides when the token can retire.
module fanout_done_tracker
    import fanout_pkg::*;
#(
    parameter int unsigned NUM_OUT = NUM_OUT_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hold,
    input  logic               capture,
    input  logic [NUM_OUT-1:0] act_mask,
    input  logic [NUM_OUT-1:0] out_ready,
    output logic [NUM_OUT-1:0] out_valid,
    output logic               retire
);

    logic [NUM_OUT-1:0] done_q;
    logic [NUM_OUT-1:0] take;

    always_comb begin
        out_valid = {NUM_OUT{hold}} & act_mask & ~done_q;
        take      = out_valid & out_ready;
        // Inactive destinations count as already done, so an all-zero mask retires at once.
        retire    = hold & (&(~act_mask | done_q | take));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= '0;
        end else if (capture || retire) begin
            done_q <= '0;
        end else if (hold) begin
            done_q <= done_q | take;
        end
    end

endmodule

// File: rtl/fanout_eager_fork.sv
// Registered one-to-many eager fork: holds one token and broadcasts it until every active
// destination has accepted it. Define FANOUT_FORK_STATS_EN to add stall/token counters.
module fanout_eager_fork
    import fanout_pkg::*;
#(
    parameter int unsigned NUM_OUT = NUM_OUT_DEFAULT,
    parameter int unsigned DATA_W  = DATA_W_DEFAULT
`ifdef FANOUT_FORK_STATS_EN
    ,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_OUT-1:0] cfg_en,
    input  logic [NUM_OUT-1:0] cfg_sel,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic [NUM_OUT-1:0] out_valid,
    input  logic [NUM_OUT-1:0] out_ready
`ifdef FANOUT_FORK_STATS_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   tok_cnt
`endif
);

    fork_state_t        state_q;
    logic [DATA_W-1:0]  hold_data_q;
    logic [NUM_OUT-1:0] act_mask_q;
    logic [NUM_OUT-1:0] act_new;
    logic               hold;
    logic               capture;
    logic               retire;

    if (NUM_OUT == NUM_OUT_DEFAULT) begin : g_pkg_mask
        assign act_new = act_mask_f(cfg_en, cfg_sel);
    end else begin : g_raw_mask
        assign act_new = cfg_en & cfg_sel;
    end

    // Gating with reset keeps a token being dropped from completing any handshake.
    assign hold     = (state_q == HOLD) & ~reset;
    assign in_ready = ~reset & ((state_q == EMPTY) | retire);
    assign capture  = in_valid & in_ready;
    assign out_data = hold_data_q;

    fanout_done_tracker #(
        .NUM_OUT (NUM_OUT)
    ) u_tracker (
        .clk       (clk),
        .reset     (reset),
        .hold      (hold),
        .capture   (capture),
        .act_mask  (act_mask_q),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .retire    (retire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            hold_data_q <= '0;
            act_mask_q  <= '0;
        end else if (capture) begin
            state_q     <= HOLD;
            hold_data_q <= in_data;
            act_mask_q  <= act_new;
        end else if (retire) begin
            state_q     <= EMPTY;
        end
    end

`ifdef FANOUT_FORK_STATS_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] tok_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
            tok_q   <= '0;
        end else begin
            if (hold && !retire && stall_q != '1) begin
                stall_q <= stall_q + 1'b1;
            end
            if (retire && tok_q != '1) begin
                tok_q <= tok_q + 1'b1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign tok_cnt   = tok_q;
`endif

endmodule
